// File: rtl/cpu_pkg.sv
// Shared datapath constants for the CPU: word/immediate widths and the
// immediate-extender mode encodings.
package cpu_pkg;

   localparam int WORD_W = 32;
   localparam int IMM_W  = 16;

   localparam logic [1:0] SE_SEXT   = 2'b00;
   localparam logic [1:0] SE_ZEXT   = 2'b01;
   localparam logic [1:0] SE_BRANCH = 2'b10;
   localparam logic [1:0] SE_UPPER  = 2'b11;

endpackage

// File: rtl/extend_core.sv
// Combinational immediate widener: selects sign-, zero-, branch- or
// upper-extension of the raw immediate field.
module extend_core
   import cpu_pkg::*;
#(
   parameter int IN_W  = IMM_W,
   parameter int OUT_W = WORD_W
) (
   input  logic [IN_W-1:0]  se_in,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] se_out
);

   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] branch;
   logic [OUT_W-1:0] upper;

   // Casts rather than replication so that IN_W == OUT_W needs no zero-width fill.
   assign sext   = OUT_W'($signed(se_in));
   assign zext   = OUT_W'(se_in);
   assign branch = sext << 2;
   assign upper  = zext << (OUT_W - IN_W);

   always_comb begin
      se_out = sext;
      case (mode)
         SE_SEXT:   se_out = sext;
         SE_ZEXT:   se_out = zext;
         SE_BRANCH: se_out = branch;
         SE_UPPER:  se_out = upper;
         default:   se_out = sext;
      endcase
   end

endmodule

// File: rtl/sign_extend.sv
// Immediate extender: combinational result for the single-cycle ALU-B mux
// plus a registered, valid-qualified copy for a pipelined ID/EX stage.
module sign_extend
   import cpu_pkg::*;
#(
   parameter int IN_W  = IMM_W,
   parameter int OUT_W = WORD_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  se_in,
   input  logic [1:0]       mode,
   input  logic             valid_in,
   output logic [OUT_W-1:0] se_out,
   output logic [OUT_W-1:0] se_out_q,
   output logic             valid_out
);

   extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .se_in  (se_in),
      .mode   (mode),
      .se_out (se_out)
   );

   // Data register only loads on valid so a bubble leaves the last operand visible.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         se_out_q  <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            se_out_q <= se_out;
         end
      end
   end

endmodule

// File: tb/tb_sign_extend.sv
// Directed bench for sign_extend: combinational results checked inline,
// registered path checked by a queue-based scoreboard monitor.
module tb_sign_extend;

   logic        clk;
   logic        reset;
   logic [15:0] se_in;
   logic [1:0]  mode;
   logic        valid_in;
   logic [31:0] se_out;
   logic [31:0] se_out_q;
   logic        valid_out;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] last_q = '0;

   typedef struct {
      logic [1:0]  m;
      logic [15:0] imm;
      logic [31:0] exp;
      logic        vld;
   } vec_t;

   vec_t vecs[$];

   sign_extend dut (
      .clk       (clk),
      .reset     (reset),
      .se_in     (se_in),
      .mode      (mode),
      .valid_in  (valid_in),
      .se_out    (se_out),
      .se_out_q  (se_out_q),
      .valid_out (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Drive one vector after the edge, check the combinational output, queue the registered result.
   task automatic apply(input vec_t v);
      @(posedge clk);
      #2;
      mode     = v.m;
      se_in    = v.imm;
      valid_in = v.vld;
      #1;
      check($sformatf("se_out mode=%0d in=%04h", v.m, v.imm), se_out, v.exp);
      if (v.vld) exp_q.push_back(v.exp);
   endtask

   // Monitor: pops on valid_out, otherwise requires the register to hold.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         last_q = '0;
      end else if (valid_out) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected valid_out: se_out_q=%08h with empty scoreboard", se_out_q);
         end else begin
            last_q = exp_q.pop_front();
            check("se_out_q", se_out_q, last_q);
         end
      end else begin
         check("se_out_q hold", se_out_q, last_q);
      end
   end

   initial begin
      vecs.push_back('{2'b00, 16'hFFFF, 32'hFFFFFFFF, 1'b1});
      vecs.push_back('{2'b00, 16'h7FFF, 32'h00007FFF, 1'b1});
      vecs.push_back('{2'b00, 16'h8000, 32'hFFFF8000, 1'b1});
      vecs.push_back('{2'b01, 16'hFFFF, 32'h0000FFFF, 1'b1});
      vecs.push_back('{2'b01, 16'h0000, 32'h00000000, 1'b1});
      vecs.push_back('{2'b10, 16'hFFFF, 32'hFFFFFFFC, 1'b1});
      vecs.push_back('{2'b10, 16'h8000, 32'hFFFE0000, 1'b1});
      vecs.push_back('{2'b10, 16'h0001, 32'h00000004, 1'b1});
      vecs.push_back('{2'b11, 16'hABCD, 32'hABCD0000, 1'b1});
      vecs.push_back('{2'b11, 16'h8000, 32'h80000000, 1'b1});
      vecs.push_back('{2'b00, 16'h8001, 32'hFFFF8001, 1'b1});
      vecs.push_back('{2'b01, 16'h1234, 32'h00001234, 1'b0});
      vecs.push_back('{2'b11, 16'h00FF, 32'h00FF0000, 1'b0});
      vecs.push_back('{2'b10, 16'h4000, 32'h00010000, 1'b1});

      reset    = 1'b1;
      se_in    = '0;
      mode     = 2'b00;
      valid_in = 1'b0;
      #1;
      check("reset se_out_q", se_out_q, 32'h0);
      check("reset valid_out", {31'b0, valid_out}, 32'h0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;

      foreach (vecs[i]) apply(vecs[i]);

      // Reset between edges with a result in flight: it must be discarded.
      apply('{2'b00, 16'h0F0F, 32'h00000F0F, 1'b1});
      @(posedge clk);
      #2;
      check("pre-reset se_out_q", se_out_q, 32'h00000F0F);
      mode     = 2'b00;
      se_in    = 16'h7000;
      valid_in = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("async reset se_out_q", se_out_q, 32'h0);
      check("async reset valid_out", {31'b0, valid_out}, 32'h0);
      se_in    = 16'hFFFF;
      valid_in = 1'b0;
      #1;
      check("se_out during reset", se_out, 32'hFFFFFFFF);
      @(posedge clk);
      #1;
      check("reset held se_out_q", se_out_q, 32'h0);
      @(negedge clk);
      #2 reset = 1'b0;

      apply('{2'b01, 16'h8421, 32'h00008421, 1'b0});
      apply('{2'b11, 16'h0001, 32'h00010000, 1'b1});
      apply('{2'b00, 16'hC000, 32'hFFFFC000, 1'b0});

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard drained", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
